// File: rtl/mult_result_checker.sv
// Self-checking monitor for pipelined multipliers: tracks issued operand pairs, compares the DUT
// product LATENCY cycles later, keeps saturating counters and captures the first mismatch.
module mult_result_checker #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned SIGNED  = 0,
  parameter int unsigned TOL     = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     mx,
  input  logic [WIDTH-1:0]     my,
  input  logic [2*WIDTH-1:0]   product,
  output logic [CNT_W-1:0]     chk_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     tol_err_cnt,
  output logic                 err_pulse,
  output logic                 fe_valid,
  output logic [WIDTH-1:0]     fe_mx,
  output logic [WIDTH-1:0]     fe_my,
  output logic [2*WIDTH-1:0]   fe_exp,
  output logic [2*WIDTH-1:0]   fe_got
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned DW = PW + 1;
  localparam int unsigned CW = (DW > 32) ? DW : 32;

  typedef enum logic {StEmpty, StHeld} fe_state_e;

  // ---------------------------------------------------------------------------------------------
  // Golden product at issue time
  // ---------------------------------------------------------------------------------------------
  logic          mx_sx, my_sx;
  logic [PW-1:0] mx_ext, my_ext, exp_now;

  // Low PW bits of the sign-extended product equal the two's-complement product.
  assign mx_sx   = (SIGNED != 0) & mx[WIDTH-1];
  assign my_sx   = (SIGNED != 0) & my[WIDTH-1];
  assign mx_ext  = {{WIDTH{mx_sx}}, mx};
  assign my_ext  = {{WIDTH{my_sx}}, my};
  assign exp_now = mx_ext * my_ext;

  // ---------------------------------------------------------------------------------------------
  // In-flight pipeline: valid chain is reset, data stages are not
  // ---------------------------------------------------------------------------------------------
  logic [LATENCY-1:0] vld_q;
  logic [WIDTH-1:0]   mx_q  [LATENCY];
  logic [WIDTH-1:0]   my_q  [LATENCY];
  logic [PW-1:0]      exp_q [LATENCY];

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_q <= '0;
    end else begin
      vld_q <= (vld_q << 1) | LATENCY'(in_valid);
    end
  end

  always_ff @(posedge CLK) begin
    mx_q[0]  <= mx;
    my_q[0]  <= my;
    exp_q[0] <= exp_now;
    for (int i = 1; i < LATENCY; i++) begin
      mx_q[i]  <= mx_q[i-1];
      my_q[i]  <= my_q[i-1];
      exp_q[i] <= exp_q[i-1];
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Compare against the tail entry
  // ---------------------------------------------------------------------------------------------
  logic             cmp;
  logic             mismatch;
  logic             tol_viol;
  logic [WIDTH-1:0] t_mx, t_my;
  logic [PW-1:0]    t_exp;
  logic [DW-1:0]    prod_w, exp_w, diff, abs_diff;

  assign cmp   = vld_q[LATENCY-1];
  assign t_mx  = mx_q[LATENCY-1];
  assign t_my  = my_q[LATENCY-1];
  assign t_exp = exp_q[LATENCY-1];

  always_comb begin
    prod_w   = {(SIGNED != 0) & product[PW-1], product};
    exp_w    = {(SIGNED != 0) & t_exp[PW-1], t_exp};
    diff     = prod_w - exp_w;
    // One extra bit keeps the difference exact in both signedness modes.
    abs_diff = diff[DW-1] ? (DW'(0) - diff) : diff;
    mismatch = cmp & (product != t_exp);
    tol_viol = cmp & (CW'(abs_diff) > CW'(TOL));
  end

  // ---------------------------------------------------------------------------------------------
  // Saturating counters and error pulse
  // ---------------------------------------------------------------------------------------------
  logic [CNT_W-1:0] chk_cnt_q, err_cnt_q, tol_cnt_q;
  logic             err_pulse_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      chk_cnt_q   <= '0;
      err_cnt_q   <= '0;
      tol_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
    end else if (clr) begin
      chk_cnt_q   <= '0;
      err_cnt_q   <= '0;
      tol_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      if (cmp)      chk_cnt_q <= sat_inc(chk_cnt_q);
      if (mismatch) err_cnt_q <= sat_inc(err_cnt_q);
      if (tol_viol) tol_cnt_q <= sat_inc(tol_cnt_q);
      err_pulse_q <= mismatch;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // First-error capture FSM
  // ---------------------------------------------------------------------------------------------
  fe_state_e fe_state_q, fe_state_d;
  logic      fe_load;

  always_comb begin
    fe_state_d = fe_state_q;
    fe_load    = 1'b0;
    if (clr) begin
      fe_state_d = StEmpty;
    end else begin
      case (fe_state_q)
        StEmpty: begin
          if (mismatch) begin
            fe_load    = 1'b1;
            fe_state_d = StHeld;
          end
        end
        StHeld:  fe_state_d = StHeld;
        default: fe_state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fe_state_q <= StEmpty;
    end else begin
      fe_state_q <= fe_state_d;
    end
  end

  logic [WIDTH-1:0] fe_mx_q, fe_my_q;
  logic [PW-1:0]    fe_exp_q, fe_got_q;

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      fe_mx_q  <= '0;
      fe_my_q  <= '0;
      fe_exp_q <= '0;
      fe_got_q <= '0;
    end else if (fe_load) begin
      fe_mx_q  <= t_mx;
      fe_my_q  <= t_my;
      fe_exp_q <= t_exp;
      fe_got_q <= product;
    end
  end

  assign chk_cnt     = chk_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign tol_err_cnt = tol_cnt_q;
  assign err_pulse   = err_pulse_q;
  assign fe_valid    = (fe_state_q == StHeld);
  assign fe_mx       = fe_mx_q;
  assign fe_my       = fe_my_q;
  assign fe_exp      = fe_exp_q;
  assign fe_got      = fe_got_q;

endmodule

// File: doc/mult_result_checker.md
Name: mult_result_checker

Overview:
Synthesizable, parametrised self-checking monitor for pipelined multiplier datapaths such as the radix-8 Booth units. It samples operand pairs and computes the golden product internally. It then compares the multiplier's product output exactly LATENCY cycles later and keeps saturating check, error and out-of-tolerance counters. It also captures the first failing sample, so exact and approximate multipliers can be checked on-chip or in simulation without a behavioural scoreboard.

Parameters:
WIDTH, 16, operand width in bits; product width is 2*WIDTH.
LATENCY, 3, DUT pipeline depth in cycles; legal range 1..16.
SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands and product.
TOL, 0, maximum allowed |product - expected| before a sample counts as out-of-tolerance.
CNT_W, 16, width of all counters.

Ports:
CLK  in  1  clock; all state updates on rising edge.
RST  in  1  synchronous reset, active-high.
clr  in  1  synchronous clear of counters and first-error capture; pipeline is untouched.
in_valid  in  1  operand pair on mx/my is issued to the DUT this cycle.
mx  in  WIDTH  multiplicand.
my  in  WIDTH  multiplier.
product  in  2*WIDTH  DUT product output.
chk_cnt  out  CNT_W  number of samples compared.
err_cnt  out  CNT_W  samples with product != expected.
tol_err_cnt  out  CNT_W  samples with |product - expected| > TOL.
err_pulse  out  1  registered one-cycle flag for an exact mismatch.
fe_valid  out  1  sticky flag: first-error capture holds data.
fe_mx  out  WIDTH  operand mx of the first mismatch.
fe_my  out  WIDTH  operand my of the first mismatch.
fe_exp  out  2*WIDTH  expected product of the first mismatch.
fe_got  out  2*WIDTH  DUT product of the first mismatch.

Behaviour:
- Reset (RST=1 at an edge): all outputs become 0, and all pipeline valid bits become 0. Operand and expected data registers need not be reset.
- Issue: at edge k with in_valid=1, the checker latches {mx, my, expected}.
  - Expected is mx*my at 2*WIDTH bits: unsigned when SIGNED=0, sign-extended operands when SIGNED=1.
  - The entry enters a LATENCY-deep shift register, valid bit included.
- Compare: at edge k+LATENCY, the tail entry is valid and `product` is sampled.
  - This matches the DUT contract: a result is stable at its output LATENCY edges after its operands were sampled.
- Difference: computed in 2*WIDTH+1 bits, signed when SIGNED=1. The absolute value is compared against TOL.
- Per compare:
  - chk_cnt increments by 1.
  - On mismatch, err_cnt increments by 1.
  - If the absolute difference exceeds TOL, tol_err_cnt increments by 1.
  - All counters saturate at 2^CNT_W-1 and never wrap.
- err_pulse = 1 on the edge following a compare that mismatched; otherwise 0.
- First-error capture: on the first mismatch while fe_valid=0, load fe_* from the tail entry and DUT product, and set fe_valid. Later mismatches leave fe_* unchanged.
- Back-to-back issue every cycle is supported; gaps (in_valid=0) create bubbles that are not compared.
- clr=1: counters, err_pulse source and fe_* are zeroed at that edge.
  - clr wins over a simultaneous compare; that compare is neither counted nor captured.
  - In-flight entries are kept and compared on later edges.
- RST mid-stream: all in-flight entries are discarded, so no compare happens for LATENCY cycles after RST deasserts unless new issues arrive. RST has priority over clr.
- TOL=0: tol_err_cnt equals err_cnt.
- Control path: a shift-register valid chain plus a 2-state capture FSM (EMPTY/HELD). HELD exits only via RST or clr.

Test Plan:
1. WIDTH=16, LATENCY=3, SIGNED=0. Issue mx=0x0003, my=0x0005; drive product=0x0000000F at the third edge after issue. Required: chk_cnt=1, err_cnt=0, err_pulse never asserted.
2. Same config, TOL=2. Issue 0x0003*0x0005; return 0x00000010. Required: err_cnt=1, tol_err_cnt=0, fe_valid=1, fe_mx=3, fe_my=5, fe_exp=0xF, fe_got=0x10, one-cycle err_pulse. A second mismatch 0x1234*0x0002 returning 0 leaves fe_* unchanged and gives err_cnt=2, tol_err_cnt=1.
3. SIGNED=1. Issue 0xFFFF*0x0002 returning 0xFFFFFFFE -> no error. Issue 0x8000*0x8000 returning 0x40000000 -> no error. Returning 0x3FFFFFFF with TOL=0 -> err_cnt=1, tol_err_cnt=1.
4. CNT_W=4, 20 consecutive back-to-back mismatching issues -> chk_cnt=15, err_cnt=15, tol_err_cnt=15 after saturation; no wrap to 0.
5. Assert clr in the same cycle as a mismatching compare with 2 further issues in flight, both mismatching. Required: after the clr edge all counters are 0 and fe_valid=0. Then err_cnt=2 and fe_* holds the first of the two later samples.
6. Issue 3 samples, assert RST for 1 cycle before any compare, and drive wrong products throughout. Required: all counters remain 0 and fe_valid=0 for the following 5 cycles.
